// File: rtl/fd_ctrl_pkg.sv
// Shared constants and types for the fetch/decode sequencer.
// Opcodes, functs, ALU codes, FSM states, instruction classes.
package fd_ctrl_pkg;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_J    = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_R, C_ADDI, C_LW, C_SW, C_BEQ, C_J
  } cls_t;

endpackage

// File: rtl/fd_sequencer_if.sv
// Memory-side bus of the sequencer: pc, fetch and data handshakes.
// master = sequencer, slave = memory system.
interface fd_sequencer_if #(
  parameter int PC_W = 7
);
  logic [PC_W-1:0] pc;
  logic            imem_req;
  logic            imem_ack;
  logic            dmem_rd;
  logic            dmem_wr;
  logic            dmem_ack;

  modport master (
    output pc, imem_req, dmem_rd, dmem_wr,
    input  imem_ack, dmem_ack
  );

  modport slave (
    input  pc, imem_req, dmem_rd, dmem_wr,
    output imem_ack, dmem_ack
  );
endinterface

// File: rtl/fd_alu_decoder.sv
// Combinational opcode/funct decode into ALU op and class.
// Anything not recognised raises illegal.
module fd_alu_decoder
  import fd_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output cls_t       cls,
  output logic       illegal
);

  always_comb begin
    alu_op  = ALU_AND;
    cls     = C_R;
    illegal = 1'b0;
    unique case (1'b1)
      opcode == OP_R: begin
        cls = C_R;
        unique case (1'b1)
          funct == FN_ADD: alu_op = ALU_ADD;
          funct == FN_SUB: alu_op = ALU_SUB;
          funct == FN_AND: alu_op = ALU_AND;
          funct == FN_OR:  alu_op = ALU_OR;
          funct == FN_SLT: alu_op = ALU_SLT;
          default:         illegal = 1'b1;
        endcase
      end
      opcode == OP_ADDI: begin
        cls    = C_ADDI;
        alu_op = ALU_ADD;
      end
      opcode == OP_LW: begin
        cls    = C_LW;
        alu_op = ALU_ADD;
      end
      opcode == OP_SW: begin
        cls    = C_SW;
        alu_op = ALU_ADD;
      end
      opcode == OP_BEQ: begin
        cls    = C_BEQ;
        alu_op = ALU_SUB;
      end
      opcode == OP_J: cls = C_J;
      default:        illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/fd_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer.
// Owns the pc; every output is a register.
module fd_sequencer
  import fd_ctrl_pkg::*;
#(
  parameter int              PC_W     = 7,
  parameter logic [PC_W-1:0] PC_RESET = '0,
  parameter int              PC_STEP  = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  fd_sequencer_if.master mem,
  input  logic [5:0]     opcode,
  input  logic [5:0]     funct,
  input  logic [15:0]    imm,
  input  logic [25:0]    jaddr,
  input  logic           zero,
  output logic           ir_write,
  output logic           reg_write,
  output logic           reg_dst,
  output logic           mem_to_reg,
  output logic           alu_src,
  output logic [3:0]     alu_op,
  output logic [2:0]     state,
  output logic           illegal
);

  localparam logic [PC_W-1:0] STEP = PC_W'(PC_STEP);

  state_t          state_q, nstate;
  cls_t            cls_q, dec_cls;
  logic [3:0]      dec_op;
  logic            dec_illegal;
  logic            fetch_done;
  logic            mem_done;
  logic [PC_W-1:0] pc_next;
  logic [27:0]     jtgt;
  logic [31:0]     boff;

  fd_alu_decoder u_dec (
    .opcode  (opcode),
    .funct   (funct),
    .alu_op  (dec_op),
    .cls     (dec_cls),
    .illegal (dec_illegal)
  );

  assign state = state_q;
  assign jtgt  = {jaddr, 2'b00};
  assign boff  = {{14{imm[15]}}, imm, 2'b00};

  // Acks only count while the matching request is visible
  assign fetch_done = (state_q == S_FETCH) && mem.imem_req && mem.imem_ack;
  assign mem_done   = (mem.dmem_rd || mem.dmem_wr) && mem.dmem_ack;

  always_comb begin
    nstate  = state_q;
    pc_next = mem.pc;
    unique case (state_q)
      S_FETCH: begin
        if (fetch_done) begin
          nstate  = S_DECODE;
          pc_next = mem.pc + STEP;
        end
      end
      S_DECODE: begin
        if (dec_illegal) begin
          nstate = S_HALT;
        end else if (dec_cls == C_J) begin
          nstate  = S_FETCH;
          pc_next = jtgt[PC_W-1:0];
        end else begin
          nstate = S_EXEC;
        end
      end
      S_EXEC: begin
        unique case (cls_q)
          C_BEQ: begin
            nstate = S_FETCH;
            if (zero) pc_next = mem.pc + boff[PC_W-1:0];
          end
          C_LW, C_SW: nstate = S_MEM;
          default:    nstate = S_WB;
        endcase
      end
      S_MEM: begin
        if (mem_done) nstate = (cls_q == C_LW) ? S_WB : S_FETCH;
      end
      S_WB:    nstate = S_FETCH;
      S_HALT:  nstate = S_HALT;
      default: nstate = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_FETCH;
      mem.pc       <= PC_RESET;
      mem.imem_req <= 1'b0;
      mem.dmem_rd  <= 1'b0;
      mem.dmem_wr  <= 1'b0;
      ir_write     <= 1'b0;
      reg_write    <= 1'b0;
      reg_dst      <= 1'b0;
      mem_to_reg   <= 1'b0;
      alu_src      <= 1'b0;
      alu_op       <= ALU_AND;
      cls_q        <= C_R;
      illegal      <= 1'b0;
    end else begin
      state_q      <= nstate;
      mem.pc       <= pc_next;
      mem.imem_req <= nstate == S_FETCH;
      mem.dmem_rd  <= (nstate == S_MEM) && (cls_q == C_LW);
      mem.dmem_wr  <= (nstate == S_MEM) && (cls_q == C_SW);
      ir_write     <= fetch_done;
      reg_write    <= nstate == S_WB;
      if (state_q == S_DECODE) begin
        cls_q      <= dec_cls;
        alu_op     <= dec_op;
        alu_src    <= dec_cls inside {C_ADDI, C_LW, C_SW};
        reg_dst    <= dec_cls == C_R;
        mem_to_reg <= dec_cls == C_LW;
      end
      if (nstate == S_HALT) illegal <= 1'b1;
    end
  end

endmodule
